// File: rtl/train_dispatcher.sv
// Nibble FIFO plus frame dispatcher feeding the train-stack permutation checker.
// Optional pass/fail statistics counters are enabled by defining STATS_EN.
module train_dispatcher #(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_CARS   = 10
`ifdef STATS_EN
  , parameter int CNT_W    = 8
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             host_valid,
  input  logic [3:0]       host_data,
  output logic             host_ready,
  output logic             chk_in_valid,
  output logic [3:0]       chk_data,
  input  logic             chk_out_valid,
  input  logic             chk_result,
  output logic             res_valid,
  output logic             res_pass,
  output logic             res_err,
  output logic             busy
`ifdef STATS_EN
  , output logic [CNT_W-1:0] pass_cnt
  , output logic [CNT_W-1:0] fail_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(MAX_CARS + 2);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_REPORT} state_t;

  state_t        state;
  logic [3:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [RW-1:0] remaining;
  logic [3:0]    head;
  logic          head_bad;
  logic          frame_ready;
  logic          push;
  logic          pop;

  assign host_ready = (count < CW'(FIFO_DEPTH));
  assign push       = host_valid & host_ready;
  assign head       = mem[rd_ptr];
  assign busy       = (state != S_IDLE);

  always_comb begin
    head_bad    = (head == 4'd0) || (int'(head) > MAX_CARS);
    frame_ready = int'(count) >= int'(head) + 1;
    pop         = 1'b0;
    case (state)
      S_IDLE:  pop = (count != '0) && head_bad;
      S_SEND:  pop = 1'b1;
      default: pop = 1'b0;
    endcase
  end

  // NOTE: the storage array has no reset; pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= host_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: all state and outputs here use <= so every branch sees the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      remaining    <= '0;
      chk_in_valid <= 1'b0;
      chk_data     <= 4'd0;
      res_valid    <= 1'b0;
      res_pass     <= 1'b0;
      res_err      <= 1'b0;
    end else begin
      chk_in_valid <= 1'b0;
      res_valid    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (count != '0) begin
            if (head_bad) begin
              res_err   <= 1'b1;
              res_pass  <= 1'b0;
              res_valid <= 1'b1;
              state     <= S_REPORT;
            end else if (frame_ready) begin
              // Only whole frames are started, so the burst never stalls mid-way.
              remaining <= RW'(int'(head) + 1);
              state     <= S_SEND;
            end
          end
        end
        S_SEND: begin
          chk_in_valid <= 1'b1;
          chk_data     <= head;
          remaining    <= remaining - RW'(1);
          if (remaining == RW'(1)) state <= S_WAIT;
        end
        S_WAIT: begin
          if (chk_out_valid) begin
            res_pass  <= chk_result;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            state     <= S_REPORT;
          end
        end
        S_REPORT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

`ifdef STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (res_valid) begin
      if (res_pass) begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
      end else begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_train_dispatcher.sv
// Bench for train_dispatcher: directed frames plus random traffic against a frame-level model,
// with a behavioural stack-permutation checker answering each burst.
module tb_train_dispatcher;

  localparam int MAX_CARS = 10;

  typedef logic [3:0] nib_q_t [$];
  typedef struct packed { logic pass; logic err; } res_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       host_valid;
  logic [3:0] host_data;
  logic       host_ready;
  logic       chk_in_valid;
  logic [3:0] chk_data;
  logic       chk_out_valid;
  logic       chk_result;
  logic       res_valid;
  logic       res_pass;
  logic       res_err;
  logic       busy;
`ifdef STATS_EN
  logic [7:0] pass_cnt;
  logic [7:0] fail_cnt;
  int         exp_pass_cnt = 0;
  int         exp_fail_cnt = 0;
`endif

  train_dispatcher dut (
    .clk(clk), .rst_n(rst_n),
    .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
    .chk_in_valid(chk_in_valid), .chk_data(chk_data),
    .chk_out_valid(chk_out_valid), .chk_result(chk_result),
    .res_valid(res_valid), .res_pass(res_pass), .res_err(res_err),
    .busy(busy)
`ifdef STATS_EN
    , .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
`endif
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  nib_q_t host_q;
  nib_q_t exp_nib_q;
  res_t   exp_res_q [$];
  bit     verdict_q [$];
  nib_q_t burst;
  res_t   r;
  int     valid_cycles = 0;
  int     res_seen = 0;
  bit     silent = 1'b0;
  bit     spur_req = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Train-stack rule: cars enter in order 1..N and may leave only from the top of the stack.
  function automatic bit stack_ok(input nib_q_t f);
    int stk [$];
    int nxt;
    int x;
    nxt = 1;
    for (int i = 1; i <= int'(f[0]); i++) begin
      x = int'(f[i]);
      while (nxt <= x) begin
        stk.push_back(nxt);
        nxt++;
      end
      if (stk.size() > 0 && stk[$] == x) void'(stk.pop_back());
      else return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic nib_q_t gen_perm(input int n);
    nib_q_t out;
    int stk [$];
    int nxt;
    nxt = 1;
    while (out.size() < n) begin
      if (stk.size() == 0 || (nxt <= n && ($urandom % 2) == 0)) begin
        stk.push_back(nxt);
        nxt++;
      end else begin
        out.push_back(4'(stk.pop_back()));
      end
    end
    return out;
  endfunction

  // Frame-level model: turn the accepted nibble stream into expected bursts and results.
  function automatic void parse();
    int     h;
    nib_q_t fr;
    while (host_q.size() > 0) begin
      h = int'(host_q[0]);
      if (h == 0 || h > MAX_CARS) begin
        void'(host_q.pop_front());
        exp_res_q.push_back('{pass: 1'b0, err: 1'b1});
      end else if (host_q.size() >= h + 1) begin
        fr.delete();
        for (int i = 0; i <= h; i++) fr.push_back(host_q.pop_front());
        foreach (fr[i]) exp_nib_q.push_back(fr[i]);
        exp_res_q.push_back('{pass: stack_ok(fr), err: 1'b0});
      end else begin
        break;
      end
    end
  endfunction

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      burst.delete();
    end else begin
      if (chk_in_valid) begin
        valid_cycles++;
        burst.push_back(chk_data);
        if (exp_nib_q.size() == 0) check("chk_unexpected", 1, 0);
        else check("chk_data", chk_data, exp_nib_q.pop_front());
        if (burst.size() == int'(burst[0]) + 1) begin
          verdict_q.push_back(stack_ok(burst));
          burst.delete();
        end
      end else if (burst.size() != 0) begin
        check("chk_gap", burst.size(), 0);
        burst.delete();
      end
      if (res_valid) begin
        res_seen++;
        if (exp_res_q.size() == 0) begin
          check("res_unexpected", 1, 0);
        end else begin
          r = exp_res_q.pop_front();
          check("res_pass", res_pass, r.pass);
          check("res_err", res_err, r.err);
`ifdef STATS_EN
          if (r.pass) exp_pass_cnt = (exp_pass_cnt < 255) ? exp_pass_cnt + 1 : 255;
          else        exp_fail_cnt = (exp_fail_cnt < 255) ? exp_fail_cnt + 1 : 255;
`endif
        end
      end
    end
  end

  // Checker model: answers each completed burst after a random latency.
  initial begin
    chk_out_valid = 1'b0;
    chk_result    = 1'b0;
    forever begin
      @(posedge clk);
      if (spur_req) begin
        spur_req = 1'b0;
        #1 chk_out_valid = 1'b1;
        chk_result = 1'b1;
        @(posedge clk);
        #1 chk_out_valid = 1'b0;
      end else if (verdict_q.size() > 0 && !silent && rst_n) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        if (verdict_q.size() > 0 && rst_n) begin
          #1 chk_out_valid = 1'b1;
          chk_result = verdict_q.pop_front();
          @(posedge clk);
          #1 chk_out_valid = 1'b0;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] d);
    int t;
    t = 0;
    host_valid = 1'b1;
    host_data  = d;
    while (!host_ready && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!host_ready) begin
      check("push_timeout", 0, 1);
    end else begin
      @(posedge clk);
      host_q.push_back(d);
      parse();
      #1;
    end
    host_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_res_q.size() > 0 && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain", exp_res_q.size(), 0);
  endtask

  initial begin
    nib_q_t fr;
    int     kind;
    int     n;
    int     snap;
    int     t;
    rst_n      = 1'b0;
    host_valid = 1'b0;
    host_data  = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_chk_in_valid", chk_in_valid, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_pass", res_pass, 0);
    check("rst_res_err", res_err, 0);
    check("rst_busy", busy, 0);
    check("rst_host_ready", host_ready, 1);
    rst_n = 1'b1;
    idle(2);

    // Achievable and non-achievable permutations of three cars.
    push(3); push(1); push(2); push(3);
    drain();
    push(3); push(3); push(1); push(2);
    drain();

    // Bad headers (zero, and above MAX_CARS) are rejected without reaching the checker.
    snap = valid_cycles;
    push(0);
    idle(4);
    check("err0_no_burst", valid_cycles, snap);
    push(1); push(1);
    drain();
    push(11); push(2); push(2); push(1);
    drain();

    // A partial frame must wait for its remaining cars.
    snap = valid_cycles;
    push(5); push(1); push(2);
    idle(20);
    check("partial_no_burst", valid_cycles, snap);
    check("partial_not_busy", busy, 0);
    push(3); push(4); push(5);
    drain();
    check("partial_burst_len", valid_cycles - snap, 6);

    // A result strobe while idle must not produce a result.
    snap = res_seen;
    spur_req = 1'b1;
    idle(6);
    check("spurious_ignored", res_seen, snap);

    // Random traffic: bad headers, maximum frames, achievable and random car orders.
    for (int f = 0; f < 40; f++) begin
      fr.delete();
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        if (($urandom % 2) == 0) fr.push_back(4'd0);
        else fr.push_back(4'($urandom_range(MAX_CARS + 1, 15)));
      end else begin
        n = (kind == 1) ? MAX_CARS : $urandom_range(1, 6);
        fr.push_back(4'(n));
        if (($urandom % 2) == 0) begin
          fr = {fr, gen_perm(n)};
        end else begin
          for (int i = 0; i < n; i++) fr.push_back(4'($urandom_range(1, n)));
        end
      end
      foreach (fr[i]) begin
        if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
        push(fr[i]);
      end
    end
    drain();

    // Silent checker: fill the FIFO to its depth, then release and recover every frame.
    silent = 1'b1;
    push(2); push(1); push(2);
    idle(3);
    check("silent_busy", busy, 1);
    for (int k = 0; k < 4; k++) begin
      push(3); push(1); push(2);
      if (k == 3) check("ready_at_15", host_ready, 1);
      push(3);
    end
    idle(1);
    check("full_not_ready", host_ready, 0);
    silent = 1'b0;
    drain();
    check("full_recovered_ready", host_ready, 1);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i <= MAX_CARS; i++) push((i == 0) ? 4'(MAX_CARS) : 4'(i));
    t = 0;
    while (!chk_in_valid && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_sending", chk_in_valid, 1);
    #1 rst_n = 1'b0;
    host_q.delete();
    exp_nib_q.delete();
    exp_res_q.delete();
    verdict_q.delete();
`ifdef STATS_EN
    exp_pass_cnt = 0;
    exp_fail_cnt = 0;
`endif
    #1;
    check("async_rst_chk_in_valid", chk_in_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_res_valid", res_valid, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", host_ready, 1);
    check("post_rst_chk_in_valid", chk_in_valid, 0);
    check("post_rst_res_pass", res_pass, 0);
    check("post_rst_res_err", res_err, 0);
    idle(5);
    check("post_rst_no_stale_burst", chk_in_valid, 0);
    push(2); push(2); push(1);
    drain();

    check("final_nibbles_left", exp_nib_q.size(), 0);
`ifdef STATS_EN
    check("pass_cnt", pass_cnt, exp_pass_cnt);
    check("fail_cnt", fail_cnt, exp_fail_cnt);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
